// File: rtl/irrigation_scheduler_multizone.sv
// Debounced tank/soil/climate sensing, round-robin zone irrigation and a 4-digit scanned status display.
// Filtered inputs lag raw by DEBOUNCE_CYCLES edges; every output is registered one edge after its cause.
module irrigation_scheduler_multizone #(
  parameter int ZONES           = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SPRINKLE_CYCLES = 16,
  parameter int DRIP_CYCLES     = 32,
  parameter int SCAN_DIV        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             high,
  input  logic             middle,
  input  logic             low,
  input  logic [ZONES-1:0] umidadeDoSolo,
  input  logic             umidadeDoAr,
  input  logic             temperatura,
  input  logic             seletor,
  output logic             erro,
  output logic             saidaDoAlarme,
  output logic             ValvulaDeEntrada,
  output logic [ZONES-1:0] ValvulaDeAspersao,
  output logic [ZONES-1:0] ValvulaDeGotejamento,
  output logic [6:0]       segments,
  output logic [3:0]       digits
);

  localparam int NIN  = ZONES + 5;
  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (SPRINKLE_CYCLES > DRIP_CYCLES) ? SPRINKLE_CYCLES : DRIP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int PW   = (ZONES > 1) ? $clog2(ZONES) : 1;
  localparam int SW   = $clog2(SCAN_DIV + 1);

  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] T_SPRINKLE = TW'(SPRINKLE_CYCLES);
  localparam logic [TW-1:0] T_DRIP     = TW'(DRIP_CYCLES);
  localparam logic [PW-1:0] PTR_LAST   = PW'(ZONES - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

  localparam logic [3:0] C_E     = 4'd10;
  localparam logic [3:0] C_A     = 4'd11;
  localparam logic [3:0] C_G     = 4'd12;
  localparam logic [3:0] C_BLANK = 4'd15;

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  logic [NIN-1:0]         raw, filt_q, filt_d;
  logic [NIN-1:0][CW-1:0] cnt_q, cnt_d;
  logic                   erro_q, alarm_q, inlet_q, inlet_d;
  state_t                 state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d, ptr_next;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   mode_q, mode_d, mode_now;
  logic [ZONES-1:0]       asp_q, asp_d, got_q, got_d, onehot;
  logic [SW-1:0]          scan_q, scan_d;
  logic [1:0]             pos_q, pos_d;
  logic [6:0]             seg_q, seg_d;
  logic [3:0]             dig_q, dig_d, code;
  logic                   high_f, middle_f, low_f, air_f, temp_f, erro_c, alarm_c;
  logic [ZONES-1:0]       soil_f;
  logic [1:0]             level;

  function automatic logic [6:0] glyph(input logic [3:0] c);
    case (c)
      4'd0:    glyph = 7'h7E;
      4'd1:    glyph = 7'h30;
      4'd2:    glyph = 7'h6D;
      4'd3:    glyph = 7'h79;
      4'd4:    glyph = 7'h33;
      4'd5:    glyph = 7'h5B;
      4'd6:    glyph = 7'h5F;
      4'd7:    glyph = 7'h70;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h7B;
      C_E:     glyph = 7'h4F;
      C_A:     glyph = 7'h77;
      C_G:     glyph = 7'h5E;
      default: glyph = 7'h00;
    endcase
  endfunction

  assign raw      = {temperatura, umidadeDoAr, umidadeDoSolo, low, middle, high};
  assign high_f   = filt_q[0];
  assign middle_f = filt_q[1];
  assign low_f    = filt_q[2];
  assign soil_f   = filt_q[3 +: ZONES];
  assign air_f    = filt_q[ZONES+3];
  assign temp_f   = filt_q[ZONES+4];

  // A filtered bit only flips on the edge that completes a full run of disagreement.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < NIN; i++) begin
      if (raw[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        filt_d[i] = raw[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    erro_c  = (high_f & ~middle_f) | (middle_f & ~low_f);
    alarm_c = erro_c | ~low_f;
    level   = high_f ? 2'd3 : middle_f ? 2'd2 : low_f ? 2'd1 : 2'd0;
    inlet_d = inlet_q;
    if (high_f | erro_c)
      inlet_d = 1'b0;
    else if (~middle_f)
      inlet_d = 1'b1;
  end

  always_comb begin
    onehot         = '0;
    onehot[ptr_q]  = 1'b1;
    ptr_next       = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    mode_now       = temp_f | ~air_f | ~middle_f;
    state_d        = state_q;
    ptr_d          = ptr_q;
    timer_d        = timer_q;
    mode_d         = mode_q;
    asp_d          = asp_q;
    got_d          = got_q;
    case (state_q)
      IDLE: begin
        if (~alarm_q & soil_f[ptr_q]) begin
          state_d = RUN;
          mode_d  = mode_now;
          timer_d = mode_now ? T_DRIP : T_SPRINKLE;
          asp_d   = mode_now ? '0 : onehot;
          got_d   = mode_now ? onehot : '0;
        end else begin
          ptr_d = ptr_next;
        end
      end
      RUN: begin
        // Alarm and expiry share one exit, so a coincident pair still yields a single GAP.
        if (alarm_q || timer_q == TW'(1)) begin
          state_d = GAP;
          asp_d   = '0;
          got_d   = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
        ptr_d   = ptr_next;
        asp_d   = '0;
        got_d   = '0;
      end
      default: begin
        state_d = IDLE;
        asp_d   = '0;
        got_d   = '0;
      end
    endcase
  end

  // Segment data is chosen for the position being enabled on this edge so digits and segments stay aligned.
  always_comb begin
    scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
    pos_d  = (scan_q == SCAN_LAST) ? pos_q + 2'd1 : pos_q;
    code   = C_BLANK;
    if (!seletor) begin
      if (pos_d == 2'd0)
        code = erro_c ? C_E : {2'b00, level};
    end else begin
      if (pos_d == 2'd0)
        code = (state_q == RUN) ? 4'(ptr_q) + 4'd1 : 4'd0;
      else if (pos_d == 2'd1 && state_q == RUN)
        code = mode_q ? C_G : C_A;
    end
    seg_d = ~glyph(code);
    dig_d = ~(4'b0001 << pos_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q  <= '0;
      cnt_q   <= '0;
      erro_q  <= 1'b0;
      alarm_q <= 1'b1;
      inlet_q <= 1'b0;
      state_q <= IDLE;
      ptr_q   <= '0;
      timer_q <= '0;
      mode_q  <= 1'b0;
      asp_q   <= '0;
      got_q   <= '0;
      scan_q  <= '0;
      pos_q   <= 2'd0;
      seg_q   <= ~7'h7E;
      dig_q   <= 4'b1110;
    end else begin
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
      erro_q  <= erro_c;
      alarm_q <= alarm_c;
      inlet_q <= inlet_d;
      state_q <= state_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
      mode_q  <= mode_d;
      asp_q   <= asp_d;
      got_q   <= got_d;
      scan_q  <= scan_d;
      pos_q   <= pos_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end
  end

  assign erro                 = erro_q;
  assign saidaDoAlarme        = alarm_q;
  assign ValvulaDeEntrada     = inlet_q;
  assign ValvulaDeAspersao    = asp_q;
  assign ValvulaDeGotejamento = got_q;
  assign segments             = seg_q;
  assign digits               = dig_q;

endmodule

// File: tb/tb_irrigation_scheduler_multizone.sv
// Directed scenario bench for the multizone irrigation scheduler; expectations are queued per cycle.
module tb_irrigation_scheduler_multizone;

  localparam int S_ERRO  = 0;
  localparam int S_ALARM = 1;
  localparam int S_INLET = 2;
  localparam int S_ASP   = 3;
  localparam int S_GOT   = 4;
  localparam int S_SEG   = 5;
  localparam int S_DIG   = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       high, middle, low;
  logic [3:0] umidadeDoSolo;
  logic       umidadeDoAr, temperatura, seletor;
  logic       erro, saidaDoAlarme, ValvulaDeEntrada;
  logic [3:0] ValvulaDeAspersao, ValvulaDeGotejamento;
  logic [6:0] segments;
  logic [3:0] digits;

  irrigation_scheduler_multizone #(
    .ZONES(4), .DEBOUNCE_CYCLES(4), .SPRINKLE_CYCLES(16), .DRIP_CYCLES(32), .SCAN_DIV(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .high(high), .middle(middle), .low(low),
    .umidadeDoSolo(umidadeDoSolo), .umidadeDoAr(umidadeDoAr), .temperatura(temperatura),
    .seletor(seletor), .erro(erro), .saidaDoAlarme(saidaDoAlarme),
    .ValvulaDeEntrada(ValvulaDeEntrada), .ValvulaDeAspersao(ValvulaDeAspersao),
    .ValvulaDeGotejamento(ValvulaDeGotejamento), .segments(segments), .digits(digits)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic string sig_name(input int sig);
    case (sig)
      S_ERRO:  return "erro";
      S_ALARM: return "alarm";
      S_INLET: return "inlet";
      S_ASP:   return "sprinkler";
      S_GOT:   return "drip";
      S_SEG:   return "segments";
      default: return "digits";
    endcase
  endfunction

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      S_ERRO:  return {31'd0, erro};
      S_ALARM: return {31'd0, saidaDoAlarme};
      S_INLET: return {31'd0, ValvulaDeEntrada};
      S_ASP:   return {28'd0, ValvulaDeAspersao};
      S_GOT:   return {28'd0, ValvulaDeGotejamento};
      S_SEG:   return {25'd0, segments};
      default: return {28'd0, digits};
    endcase
  endfunction

  task automatic expect_at(input int at, input int sig, input logic [31:0] val);
    sb.push_back('{at, sig, val});
  endtask

  // Scan position after edge k: counter restarts with reset released between edges 2 and 3.
  function automatic int pos_at(input int k);
    return ((k - 2) / 8) % 4;
  endfunction

  task automatic expect_disp(input int at, input logic [6:0] g);
    expect_at(at, S_SEG, {25'd0, ~g});
    expect_at(at, S_DIG, {28'd0, ~(4'b0001 << pos_at(at))});
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t        keep[$];
    logic [31:0] act;
    keep.delete();
    foreach (sb[i]) begin
      if (sb[i].at == cyc) begin
        act = observe(sb[i].sig);
        vectors++;
        if (act !== sb[i].val) begin
          miscompares++;
          $display("FAIL %s@%0d got %h expected %h", sig_name(sb[i].sig), cyc, act, sb[i].val);
        end
      end else if (sb[i].at < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL %s@%0d never sampled (now %0d)", sig_name(sb[i].sig), sb[i].at, cyc);
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
    vectors++;
    if ($countones({ValvulaDeAspersao, ValvulaDeGotejamento}) > 1) begin
      miscompares++;
      $display("FAIL valve_onehot@%0d got asp=%b drip=%b expected at most one high",
               cyc, ValvulaDeAspersao, ValvulaDeGotejamento);
    end
  end

  initial begin
    rst_n = 1'b1;
    {high, middle, low} = 3'b000;
    umidadeDoSolo = 4'b0000;
    umidadeDoAr = 1'b0;
    temperatura = 1'b0;
    seletor = 1'b0;
    #1 rst_n = 1'b0;

    // Reset state, then full tank.
    goto(2);
    expect_at(2, S_ALARM, 1);
    expect_at(2, S_ERRO, 0);
    expect_at(2, S_INLET, 0);
    expect_at(2, S_ASP, 0);
    expect_at(2, S_GOT, 0);
    expect_disp(2, 7'h7E);
    rst_n = 1'b1;
    {high, middle, low} = 3'b111;
    umidadeDoAr = 1'b1;
    expect_at(6, S_ALARM, 1);
    expect_at(6, S_INLET, 1);
    expect_disp(6, 7'h7E);
    expect_at(7, S_ALARM, 0);
    expect_at(7, S_INLET, 0);
    expect_at(7, S_ERRO, 0);
    expect_disp(7, 7'h79);

    // Three-cycle glitch on middle is ignored; a four-cycle drop is not.
    goto(8);
    middle = 1'b0;
    goto(11);
    middle = 1'b1;
    expect_at(14, S_ERRO, 0);
    expect_at(14, S_ALARM, 0);
    goto(13);
    middle = 1'b0;
    expect_at(17, S_ERRO, 0);
    expect_at(18, S_ERRO, 1);
    expect_at(18, S_ALARM, 1);
    expect_at(18, S_DIG, 4'b1011);
    expect_disp(35, 7'h4F);

    // Inlet hysteresis: low only -> open, middle -> hold, high -> close.
    goto(36);
    high = 1'b0;
    expect_at(40, S_INLET, 0);
    expect_at(41, S_INLET, 1);
    expect_at(41, S_ERRO, 0);
    expect_at(41, S_ALARM, 0);
    goto(44);
    middle = 1'b1;
    expect_at(49, S_INLET, 1);
    expect_at(50, S_INLET, 1);
    goto(52);
    high = 1'b1;
    expect_at(56, S_INLET, 1);
    expect_at(57, S_INLET, 0);

    // Round-robin sprinkler over zones 1 and 3.
    goto(59);
    umidadeDoSolo = 4'b1010;
    expect_at(63, S_ASP, 0);
    expect_at(64, S_ASP, 32'h2);
    expect_at(70, S_GOT, 0);
    expect_at(79, S_ASP, 32'h2);
    expect_at(80, S_ASP, 0);
    expect_at(82, S_ASP, 0);
    expect_at(83, S_ASP, 32'h8);
    expect_at(98, S_ASP, 32'h8);
    expect_at(99, S_ASP, 0);
    expect_at(101, S_ASP, 0);
    expect_at(102, S_ASP, 32'h2);
    expect_at(117, S_ASP, 32'h2);
    expect_at(118, S_ASP, 0);

    // Hot weather: next cycle on zone 3 is a 32-cycle drip, shown on the display.
    goto(105);
    temperatura = 1'b1;
    expect_at(120, S_GOT, 0);
    expect_at(121, S_GOT, 32'h8);
    expect_at(121, S_ASP, 0);
    expect_at(152, S_GOT, 32'h8);
    expect_at(153, S_GOT, 0);
    goto(125);
    seletor = 1'b1;
    expect_disp(130, 7'h33);
    expect_disp(137, 7'h33);
    expect_disp(138, 7'h5E);
    expect_disp(145, 7'h5E);
    expect_disp(146, 7'h00);

    // Zone 1 drip aborted by the low probe drying out.
    expect_at(156, S_GOT, 32'h2);
    goto(160);
    low = 1'b0;
    seletor = 1'b0;
    expect_disp(162, 7'h79);
    expect_at(164, S_ALARM, 0);
    expect_at(165, S_ALARM, 1);
    expect_at(165, S_ERRO, 1);
    expect_at(165, S_GOT, 32'h2);
    expect_disp(165, 7'h4F);
    expect_at(166, S_GOT, 0);

    // Refill, then reset in the middle of a drip clears the valve at once.
    goto(170);
    low = 1'b1;
    expect_at(175, S_ALARM, 0);
    expect_at(176, S_GOT, 0);
    expect_at(177, S_GOT, 32'h8);
    expect_at(179, S_GOT, 32'h8);
    goto(180);
    rst_n = 1'b0;
    expect_at(180, S_GOT, 0);
    expect_at(180, S_ASP, 0);
    expect_at(180, S_ALARM, 1);
    expect_at(180, S_DIG, 4'b1110);
    goto(182);
    rst_n = 1'b1;

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain %0d checks still pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
